rr_arb_mux: RTL and testbench
=============================

Name: rr_arb_mux

Overview:
- Parametrised N-input, W-bit arbitrating multiplexer with a registered output stage and valid/ready handshakes on every port.
- Successor to the plain 2:1 select mux: the select is generated internally by a round-robin arbiter (or by fixed priority), instead of being driven by the caller.
- Used to share one downstream port among several requesters, e.g. instruction fetch and load/store sharing a single memory port in the pipelined core.

Parameters:
- N, 2, number of input channels (2..8).
- W, 32, data width in bits.
- FIXED_PRIO, 0, 0 = round-robin arbitration, 1 = fixed priority (lowest index wins).
- SW, $clog2(N) (minimum 1), width of the select/index field. Derived; do not override.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-low. Sampled on the clk rising edge; 0 = reset.
- in_data  input  N*W  channel i occupies bits [i*W +: W].
- in_valid  input  N  channel i has a word to send.
- in_ready  output  N  channel i word is accepted this cycle.
- out_data  output  W  registered selected word.
- out_valid  output  1  out_data holds a valid word.
- out_ready  input  1  downstream accepts the word this cycle.
- out_sel  output  SW  index of the channel that supplied out_data.

Behaviour:
- Reset (rst == 0 at a clk edge):
  - out_valid = 0, out_data = 0, out_sel = 0.
  - Priority pointer ptr = 0.
  - Reset wins over every other event, including a transfer in progress. An in-flight word is dropped.
  - While rst == 0, in_ready is forced to 0.
- load = ~out_valid | out_ready. The output register may be written this cycle.
- Arbitration (combinational, evaluated every cycle):
  - Round-robin: the winner is the first i with in_valid[i] = 1, scanning ptr, ptr+1, ... N-1, 0, ... ptr-1 (modulo N).
  - Fixed priority: the winner is the lowest i with in_valid[i] = 1.
  - No in_valid set means no winner.
- in_ready[i] = load & (i == winner). At most one bit of in_ready is set. If there is no winner, in_ready = 0.
- Transfer in: on a clk edge with load = 1 and a winner present:
  - out_data <= in_data[winner]
  - out_sel <= winner
  - out_valid <= 1
  - Round-robin only: ptr <= (winner + 1) mod N.
- Drain: on an edge with out_valid & out_ready and no winner, out_valid <= 0. out_data and out_sel hold their last values.
- Stall: while out_valid & ~out_ready, out_data, out_sel and out_valid hold stable and in_ready = 0.
- Simultaneous drain and fill (out_valid & out_ready with a winner present): the new word is loaded on the same edge. This gives full throughput of 1 word/cycle with no bubble.
- Latency: a word is accepted at edge k and appears on out_data/out_valid after edge k (one cycle).
- ptr changes only on an accepted transfer. The pointer wrap is computed modulo N, correct for non-power-of-2 N (e.g. N = 3: 2 -> 0).
- in_valid may drop without a transfer (no hold requirement on the sources). Arbitration is recomputed each cycle, so it is glitch-free with respect to the registered outputs.
- in_data of non-selected channels never affects the outputs.

Test Plan:
1. Reset: hold rst = 0 for 2 cycles with all in_valid = 1.
   -> out_valid = 0, out_data = 0, out_sel = 0, in_ready = 0.
   After release (rst = 1), with N = 2, out_ready = 1, in_valid = 2'b11:
   -> first out_sel = 0, then out_sel = 1.
2. Round-robin fairness: N = 3, in_valid = 3'b111 constant, out_ready = 1, data ch0 = 0xA0, ch1 = 0xB1, ch2 = 0xC2.
   -> out_data sequence A0, B1, C2, A0, B1 on consecutive cycles.
   -> out_sel sequence 0, 1, 2, 0, 1 (verifies the 2 -> 0 wrap).
3. Backpressure: hold out_ready = 0 for 4 cycles after out_valid rises.
   -> out_data, out_sel and out_valid are stable, in_ready = 0.
   Raise out_ready with in_valid still set:
   -> the next word loads on that same edge, with no idle cycle.
4. Drain: single request ch1 = 0x1234_5678, then in_valid = 0, out_ready = 1.
   -> out_valid is high exactly one cycle, out_sel = 1, then out_valid = 0 with out_data still 0x1234_5678.
5. Fixed priority: FIXED_PRIO = 1, N = 4, in_valid = 4'b1110 constant, out_ready = 1.
   -> out_sel = 1 every cycle; channels 2 and 3 are never granted.
6. Reset mid-stall: out_valid = 1 with out_ready = 0, then assert rst = 0 for 1 cycle.
   -> out_valid = 0 and ptr = 0.
   After release with in_valid = all ones:
   -> the first grant goes to channel 0.

Source files
------------

// File: rtl/rr_arb_mux.sv
// rr_arb_mux: N-input arbitrating mux with round-robin or fixed-priority select,
// valid/ready on every port and a registered output stage.
module rr_arb_mux #(
  parameter int N = 2,
  parameter int W = 32,
  parameter int FIXED_PRIO = 0,
  parameter int SW = (N > 1) ? $clog2(N) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N*W-1:0] in_data,
  input  logic [N-1:0]   in_valid,
  output logic [N-1:0]   in_ready,
  output logic [W-1:0]   out_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [SW-1:0]  out_sel
);
  logic [SW-1:0] ptr, win, nxt, c;
  logic hit, load;
  assign load = ~out_valid | out_ready;
  // scan starts at ptr (or 0 for fixed priority) and wraps modulo N
  always_comb begin
    win = '0;
    hit = 1'b0;
    c = '0;
    for (int k = 0; k < N; k++) begin
      c = (FIXED_PRIO != 0) ? SW'(k) :
          ((int'(ptr) + k >= N) ? SW'(int'(ptr) + k - N) : SW'(int'(ptr) + k));
      if (!hit && in_valid[c]) begin
        hit = 1'b1;
        win = c;
      end
    end
  end
  assign nxt = (win == SW'(N - 1)) ? '0 : win + 1'b1;
  assign in_ready = (rst && load && hit) ? (N'(1) << win) : '0;
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_data <= '0;
      out_sel <= '0;
      ptr <= '0;
    end else if (load) begin
      if (hit) begin
        out_data <= in_data[win*W +: W];
        out_sel <= win;
        out_valid <= 1'b1;
        if (FIXED_PRIO == 0) ptr <= nxt;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_rr_arb_mux.sv
// tb_rr_arb_mux: directed vectors for 2-ch RR, 3-ch RR and 4-ch fixed-priority instances.
module tb_rr_arb_mux;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  int n_vec = 0;
  int n_err = 0;

  logic [63:0] d_a;
  logic [1:0] iv_a, ir_a;
  logic ordy_a, ov_a;
  logic [31:0] od_a;
  logic os_a;
  rr_arb_mux #(.N(2), .W(32), .FIXED_PRIO(0)) dut_a (
    .clk(clk), .rst(rst), .in_data(d_a), .in_valid(iv_a), .in_ready(ir_a),
    .out_data(od_a), .out_valid(ov_a), .out_ready(ordy_a), .out_sel(os_a));

  logic [95:0] d_b;
  logic [2:0] iv_b, ir_b;
  logic ordy_b, ov_b;
  logic [31:0] od_b;
  logic [1:0] os_b;
  rr_arb_mux #(.N(3), .W(32), .FIXED_PRIO(0)) dut_b (
    .clk(clk), .rst(rst), .in_data(d_b), .in_valid(iv_b), .in_ready(ir_b),
    .out_data(od_b), .out_valid(ov_b), .out_ready(ordy_b), .out_sel(os_b));

  logic [127:0] d_c;
  logic [3:0] iv_c, ir_c;
  logic ordy_c, ov_c;
  logic [31:0] od_c;
  logic [1:0] os_c;
  rr_arb_mux #(.N(4), .W(32), .FIXED_PRIO(1)) dut_c (
    .clk(clk), .rst(rst), .in_data(d_c), .in_valid(iv_c), .in_ready(ir_c),
    .out_data(od_c), .out_valid(ov_c), .out_ready(ordy_c), .out_sel(os_c));

  typedef struct {
    logic rst;
    logic [2:0] iv;
    logic ordy;
    logic [95:0] d;
    logic [2:0] ir;
    logic ov;
    logic [31:0] od;
    logic [1:0] os;
  } vec_t;
  vec_t tv[20];

  localparam logic [95:0] DA = {32'h0000_00C2, 32'h0000_00B1, 32'h0000_00A0};
  localparam logic [95:0] DB = {32'h0000_00C2, 32'h1234_5678, 32'h0000_00A0};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    d_a = {32'h22, 32'h11}; iv_a = '0; ordy_a = 1'b1;
    d_b = DA; iv_b = '0; ordy_b = 1'b1;
    d_c = {32'hD3, 32'hD2, 32'hD1, 32'hD0}; iv_c = '0; ordy_c = 1'b1;

    // reset with every request raised on the 2-channel instance
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      rst = 1'b0; iv_a = 2'b11;
      #1 chk($sformatf("a_rst%0d_ir", i), 32'(ir_a), 32'h0);
      tick();
      chk($sformatf("a_rst%0d_ov", i), 32'(ov_a), 32'h0);
      chk($sformatf("a_rst%0d_od", i), od_a, 32'h0);
      chk($sformatf("a_rst%0d_os", i), 32'(os_a), 32'h0);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      rst = 1'b1;
      #1 chk($sformatf("a_rr%0d_ir", i), 32'(ir_a), (i % 2 == 0) ? 32'h1 : 32'h2);
      tick();
      chk($sformatf("a_rr%0d_ov", i), 32'(ov_a), 32'h1);
      chk($sformatf("a_rr%0d_os", i), 32'(os_a), 32'(i % 2));
      chk($sformatf("a_rr%0d_od", i), od_a, (i % 2 == 0) ? 32'h11 : 32'h22);
    end
    @(negedge clk);
    iv_a = '0;

    // fixed priority: channel 1 always beats 2 and 3
    @(negedge clk);
    rst = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      rst = 1'b1; iv_c = 4'b1110;
      #1 chk($sformatf("c_fp%0d_ir", i), 32'(ir_c), 32'h2);
      tick();
      chk($sformatf("c_fp%0d_ov", i), 32'(ov_c), 32'h1);
      chk($sformatf("c_fp%0d_os", i), 32'(os_c), 32'h1);
      chk($sformatf("c_fp%0d_od", i), od_c, 32'hD1);
    end
    @(negedge clk);
    iv_c = '0;

    // 3-channel RR: reset, fairness with 2->0 wrap, stall, drain, reset mid-stall
    tv[0]  = '{1'b0, 3'b111, 1'b1, DA, 3'b000, 1'b0, 32'h0,         2'd0};
    tv[1]  = '{1'b0, 3'b111, 1'b1, DA, 3'b000, 1'b0, 32'h0,         2'd0};
    tv[2]  = '{1'b1, 3'b111, 1'b1, DA, 3'b001, 1'b1, 32'hA0,        2'd0};
    tv[3]  = '{1'b1, 3'b111, 1'b1, DA, 3'b010, 1'b1, 32'hB1,        2'd1};
    tv[4]  = '{1'b1, 3'b111, 1'b1, DA, 3'b100, 1'b1, 32'hC2,        2'd2};
    tv[5]  = '{1'b1, 3'b111, 1'b1, DA, 3'b001, 1'b1, 32'hA0,        2'd0};
    tv[6]  = '{1'b1, 3'b111, 1'b1, DA, 3'b010, 1'b1, 32'hB1,        2'd1};
    tv[7]  = '{1'b1, 3'b111, 1'b0, DA, 3'b000, 1'b1, 32'hB1,        2'd1};
    tv[8]  = '{1'b1, 3'b111, 1'b0, DA, 3'b000, 1'b1, 32'hB1,        2'd1};
    tv[9]  = '{1'b1, 3'b111, 1'b0, DA, 3'b000, 1'b1, 32'hB1,        2'd1};
    tv[10] = '{1'b1, 3'b111, 1'b0, DA, 3'b000, 1'b1, 32'hB1,        2'd1};
    tv[11] = '{1'b1, 3'b111, 1'b1, DA, 3'b100, 1'b1, 32'hC2,        2'd2};
    tv[12] = '{1'b1, 3'b010, 1'b1, DB, 3'b010, 1'b1, 32'h1234_5678, 2'd1};
    tv[13] = '{1'b1, 3'b000, 1'b1, DA, 3'b000, 1'b0, 32'h1234_5678, 2'd1};
    tv[14] = '{1'b1, 3'b000, 1'b1, DA, 3'b000, 1'b0, 32'h1234_5678, 2'd1};
    tv[15] = '{1'b1, 3'b001, 1'b1, DA, 3'b001, 1'b1, 32'hA0,        2'd0};
    tv[16] = '{1'b1, 3'b111, 1'b0, DA, 3'b000, 1'b1, 32'hA0,        2'd0};
    tv[17] = '{1'b0, 3'b111, 1'b0, DA, 3'b000, 1'b0, 32'h0,         2'd0};
    tv[18] = '{1'b1, 3'b111, 1'b1, DA, 3'b001, 1'b1, 32'hA0,        2'd0};
    tv[19] = '{1'b1, 3'b111, 1'b1, DA, 3'b010, 1'b1, 32'hB1,        2'd1};
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      rst = tv[i].rst; iv_b = tv[i].iv; ordy_b = tv[i].ordy; d_b = tv[i].d;
      #1 chk($sformatf("b_v%0d_ir", i), 32'(ir_b), 32'(tv[i].ir));
      tick();
      chk($sformatf("b_v%0d_ov", i), 32'(ov_b), 32'(tv[i].ov));
      chk($sformatf("b_v%0d_od", i), od_b, tv[i].od);
      chk($sformatf("b_v%0d_os", i), 32'(os_b), 32'(tv[i].os));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
